blink_control: RTL



---
 rtl/blink_control.sv | 138 +++++++++++++
 1 files changed

// File: rtl/blink_control.sv
// rtl/blink_control.sv - multi-channel debounced push-button to blinking LED controller
// Optional feature macro: LED_ACTIVE_LOW_EN (led is driven inverted and resets to all 1).
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   rst    - synchronous active-high reset
//   button - raw asynchronous buttons, active-low, bit i = channel i
//   led    - LED drive, one bit per channel
//   mode   - current mode, bits [2i+1:2i] = channel i; 0=OFF 1=ON 2=SLOW 3=FAST
module blink_control #(
  parameter int CHANNELS        = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SLOW_HALF       = 6750000,
  parameter int FAST_HALF       = 1687500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   button,
  output logic [CHANNELS-1:0]   led,
  output logic [2*CHANNELS-1:0] mode
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
  localparam int FW = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_HALF - 1);
  localparam logic [FW-1:0] FAST_LAST = FW'(FAST_HALF - 1);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_POL = 1'b1;
`else
  localparam logic LED_POL = 1'b0;
`endif
  localparam logic [CHANNELS-1:0] LED_OFF = {CHANNELS{LED_POL}};

  // Per-channel state
  logic [CHANNELS-1:0]          sync1_q, sync1_d;
  logic [CHANNELS-1:0]          sync2_q, sync2_d;
  logic [CHANNELS-1:0]          deb_q, deb_d;
  logic [CHANNELS-1:0]          press_q, press_d;
  logic [CHANNELS-1:0]          led_q, led_d;
  logic [CHANNELS-1:0][DW-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0][1:0]     mode_q, mode_d;

  // Shared blink timebase
  logic [SW-1:0] slow_cnt_q, slow_cnt_d;
  logic [FW-1:0] fast_cnt_q, fast_cnt_d;
  logic          slow_ph_q, slow_ph_d;
  logic          fast_ph_q, fast_ph_d;

  logic          led_lvl;

  always_comb begin
    slow_cnt_d = slow_cnt_q + SW'(1);
    slow_ph_d  = slow_ph_q;
    if (slow_cnt_q == SLOW_LAST) begin
      slow_cnt_d = '0;
      slow_ph_d  = ~slow_ph_q;
    end

    fast_cnt_d = fast_cnt_q + FW'(1);
    fast_ph_d  = fast_ph_q;
    if (fast_cnt_q == FAST_LAST) begin
      fast_cnt_d = '0;
      fast_ph_d  = ~fast_ph_q;
    end

    sync1_d = button;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    led_d   = led_q;
    led_lvl = 1'b0;

    for (int i = 0; i < CHANNELS; i++) begin
      // Counter only runs while the synchronised level disagrees with the
      // accepted level; it never passes DEB_LAST, so it cannot overflow.
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end

      if (press_q[i]) begin
        mode_d[i] = mode_q[i] + 2'd1;
      end

      case (mode_q[i])
        2'd0:    led_lvl = 1'b0;
        2'd1:    led_lvl = 1'b1;
        2'd2:    led_lvl = slow_ph_q;
        default: led_lvl = fast_ph_q;
      endcase
      led_d[i] = led_lvl ^ LED_POL;
    end

    // Pulse on the accepted 1->0 edge, registered in the same cycle deb falls
    // so the mode steps one edge later.
    press_d = deb_q & ~deb_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      press_q    <= '0;
      cnt_q      <= '0;
      mode_q     <= '0;
      led_q      <= LED_OFF;
      slow_cnt_q <= '0;
      fast_cnt_q <= '0;
      slow_ph_q  <= 1'b0;
      fast_ph_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      press_q    <= press_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      slow_cnt_q <= slow_cnt_d;
      fast_cnt_q <= fast_cnt_d;
      slow_ph_q  <= slow_ph_d;
      fast_ph_q  <= fast_ph_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule
